pipe_fetch: RTL and testbench

PIPE_FETCH -- requirements
Module: pipe_fetch

---
 rtl/pipe_fetch.sv | 118 +++++++++++
 tb/tb_pipe_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch.sv
// Instruction fetch stage: PC register plus a prefetch queue feeding decode.
// Define FETCH_EPC_EN to capture a return address in epc when an interrupt is taken.
module pipe_fetch #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned INST_W    = 16,
    parameter int unsigned BR_W      = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RESET_VEC = 32,
    parameter int unsigned INT_VEC   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch,
    input  logic [BR_W-1:0]   branch_addr,
    input  logic              interrupt,
    input  logic              stall,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic [PC_W-1:0]   epc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem [DEPTH];
    logic              redirect, pop, push;
    logic [PC_W-1:0]   br_ext;

    assign br_ext     = PC_W'($signed(branch_addr));
    assign redirect   = interrupt | branch;
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready & ~redirect;
    // A pop in the same cycle frees a slot, so a full queue can still accept a fetch.
    assign push       = ~stall & ~redirect & ((count_q != FULL) | pop);

    assign imem_addr  = pc_q;
    assign inst       = inst_mem[rd_q];
    assign inst_pc    = pc_mem[rd_q];

    always_comb begin
        pc_d    = pc_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (interrupt) begin
            pc_d    = PC_W'(INT_VEC);
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else if (branch) begin
            pc_d    = br_ext;
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            if (push) begin
                wr_d = wr_q + 1'b1;
                pc_d = pc_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_W'(RESET_VEC);
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            inst_mem[wr_q] <= imem_data;
            pc_mem[wr_q]   <= pc_q;
        end
    end

`ifdef FETCH_EPC_EN
    logic [PC_W-1:0] epc_q;

    // Return to the oldest unexecuted work: a same-cycle branch target wins over the queue head.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc_q <= '0;
        end else if (interrupt) begin
            epc_q <= branch ? br_ext : (inst_valid ? inst_pc : pc_q);
        end
    end

    assign epc = epc_q;
`else
    assign epc = '0;
`endif

endmodule

// File: tb/tb_pipe_fetch.sv
// Scoreboard bench for pipe_fetch: a reference model pushes expected fetch addresses,
// which are popped and compared whenever decode accepts an instruction.
module tb_pipe_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        branch = 1'b0;
    logic [15:0] branch_addr = '0;
    logic        interrupt = 1'b0;
    logic        stall = 1'b0;
    logic        inst_ready = 1'b0;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        inst_valid;
    logic [15:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] epc;

    // Narrow instance used to exercise PC wrap-around.
    logic [7:0]  imem_addr8;
    logic [15:0] imem_data8;
    logic        inst_valid8;
    logic [15:0] inst8;
    logic [7:0]  inst_pc8;
    logic [7:0]  epc8;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [7:0]  e8;
    logic        saw_wrap8;

    function automatic logic [15:0] mem_of(logic [31:0] a);
        return a[15:0] ^ {a[7:0], a[15:8]} ^ a[31:16] ^ 16'h3C96;
    endfunction

    assign imem_data  = mem_of(imem_addr);
    assign imem_data8 = {8'h00, imem_addr8};

    always #5 clk = ~clk;

    pipe_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .branch     (branch),
        .branch_addr(branch_addr),
        .interrupt  (interrupt),
        .stall      (stall),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .epc        (epc)
    );

    pipe_fetch #(
        .PC_W     (8),
        .BR_W     (8),
        .RESET_VEC(250)
    ) dut8 (
        .clk        (clk),
        .reset      (reset),
        .branch     (1'b0),
        .branch_addr(8'h00),
        .interrupt  (1'b0),
        .stall      (1'b0),
        .imem_addr  (imem_addr8),
        .imem_data  (imem_data8),
        .inst_valid (inst_valid8),
        .inst_ready (1'b1),
        .inst       (inst8),
        .inst_pc    (inst_pc8),
        .epc        (epc8)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Check outputs at the falling edge, then advance the model across the next rising edge.
    task automatic cycle();
        int unsigned n;
        logic        pop;
        logic [31:0] ext;
        @(negedge clk);
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("inst_valid", inst_valid, sb.size() != 0);
        check_eq("epc", epc, m_epc);
        if (inst_valid && sb.size() != 0) begin
            check_eq("inst_pc", inst_pc, sb[0]);
            check_eq("inst", inst, mem_of(sb[0]));
        end
        check_eq("epc8", epc8, 8'h00);
        if (inst_valid8) begin
            check_eq("inst_pc8", inst_pc8, e8);
            check_eq("inst8", inst8, {8'h00, e8});
            if (e8 == 8'h00) saw_wrap8 = 1'b1;
            e8 = e8 + 8'd1;
        end
        ext = {{16{branch_addr[15]}}, branch_addr};
        if (reset) begin
            m_pc  = 32'd32;
            m_epc = '0;
            sb.delete();
            e8 = 8'd250;
        end else if (interrupt) begin
`ifdef FETCH_EPC_EN
            m_epc = branch ? ext : (sb.size() != 0 ? sb[0] : m_pc);
`endif
            m_pc = 32'd0;
            sb.delete();
        end else if (branch) begin
            m_pc = ext;
            sb.delete();
        end else begin
            n   = sb.size();
            pop = (n != 0) && inst_ready;
            if (pop) void'(sb.pop_front());
            if (!stall && (n < 4 || pop)) begin
                sb.push_back(m_pc);
                m_pc = m_pc + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        branch = 1'b0;
        interrupt = 1'b0;
        stall = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int unsigned guard;
        logic [31:0] exp_epc;
        saw_wrap8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_pc  = 32'd32;
        m_epc = '0;
        e8    = 8'd250;

        // Free run after reset.
        reset = 1'b0;
        inst_ready = 1'b1;
        check_eq("post_reset_valid", inst_valid, 1'b0);
        cycle();
        check_eq("first_valid", inst_valid, 1'b1);
        check_eq("first_pc", inst_pc, 32'd32);
        repeat (12) cycle();

        // Back-pressure: queue fills and pc parks.
        do_reset();
        inst_ready = 1'b0;
        repeat (10) cycle();
        check_eq("full_addr", imem_addr, 32'd36);
        check_eq("full_head", inst_pc, 32'd32);
        inst_ready = 1'b1;
        repeat (8) cycle();

        // Branch with three entries queued.
        do_reset();
        inst_ready = 1'b0;
        repeat (3) cycle();
        branch = 1'b1;
        branch_addr = 16'hFFF0;
        cycle();
        branch = 1'b0;
        check_eq("br_valid", inst_valid, 1'b0);
        check_eq("br_pc", imem_addr, 32'hFFFF_FFF0);
        inst_ready = 1'b1;
        cycle();
        check_eq("br_head0", inst_pc, 32'hFFFF_FFF0);
        cycle();
        check_eq("br_head1", inst_pc, 32'hFFFF_FFF1);
        repeat (3) cycle();

        // Interrupt with head at 40.
        do_reset();
        inst_ready = 1'b1;
        guard = 0;
        while (!(inst_valid && inst_pc == 32'd40) && guard < 30) begin
            cycle();
            guard++;
        end
        check_eq("reach_head40", inst_pc, 32'd40);
        interrupt = 1'b1;
        cycle();
        interrupt = 1'b0;
`ifdef FETCH_EPC_EN
        exp_epc = 32'd40;
`else
        exp_epc = 32'd0;
`endif
        check_eq("int_epc", epc, exp_epc);
        check_eq("int_pc", imem_addr, 32'd0);
        check_eq("int_valid", inst_valid, 1'b0);
        repeat (4) cycle();

        // Interrupt and branch together, then stall with branch.
        interrupt = 1'b1;
        branch = 1'b1;
        branch_addr = 16'h0123;
        cycle();
        interrupt = 1'b0;
`ifdef FETCH_EPC_EN
        exp_epc = 32'h0000_0123;
`else
        exp_epc = 32'd0;
`endif
        check_eq("intbr_epc", epc, exp_epc);
        check_eq("intbr_pc", imem_addr, 32'd0);
        stall = 1'b1;
        branch_addr = 16'h0050;
        cycle();
        branch = 1'b0;
        check_eq("stallbr_pc", imem_addr, 32'h0000_0050);
        repeat (3) cycle();

        // Stall does not block pops.
        stall = 1'b0;
        inst_ready = 1'b0;
        repeat (4) cycle();
        stall = 1'b1;
        inst_ready = 1'b1;
        repeat (5) cycle();
        check_eq("stall_drained", inst_valid, 1'b0);
        stall = 1'b0;
        repeat (3) cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            interrupt   = ($urandom_range(0, 29) == 0);
            branch      = ($urandom_range(0, 14) == 0);
            branch_addr = 16'($urandom);
            stall       = ($urandom_range(0, 3) == 0);
            inst_ready  = ($urandom_range(0, 2) != 0);
            cycle();
        end

        check_eq("pc8_wrapped", saw_wrap8, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
